// File: rtl/mult_cell_sequencer_pkg.sv
// Shared definitions for the multiplier-cell sequencer: word sizes, FSM
// state encodings and the partial-product combine helper.
package mult_cell_sequencer_pkg;

   localparam int WORD_W  = 32;
   localparam int HALF_W  = 16;
   localparam int STATE_W = 3;

   typedef logic [STATE_W-1:0] state_t;

   localparam state_t ST_IDLE    = 3'd0;
   localparam state_t ST_ISSUE   = 3'd1;
   localparam state_t ST_WAIT    = 3'd2;
   localparam state_t ST_COMBINE = 3'd3;
   localparam state_t ST_RESP    = 3'd4;

   // Low word of a 32x32 product from the three partials that can reach it.
   // The a_hi*b_hi term only affects bits 63:32 and is never computed; the
   // upper half of (p2 + p3) and its carry fall off the top of the shift.
   function automatic logic [WORD_W-1:0] combine_partials(
      input logic [WORD_W-1:0] p1,
      input logic [WORD_W-1:0] p2,
      input logic [WORD_W-1:0] p3
   );
      logic [WORD_W-1:0] mid;
      mid = p2 + p3;
      return p1 + (mid << HALF_W);
   endfunction

endpackage

// File: rtl/mult_cell_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter: searches req starting at ptr, wrapping
// modulo NUM_REQ, and returns the first requester found.
module mult_cell_sequencer_rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               found
);

   // Priority search from ptr; the first hit wins and masks later candidates.
   always_comb begin
      logic [IDX_W:0]   sum;
      logic [IDX_W-1:0] cand;
      // NOTE: every output and temporary gets a default before the loop, so
      // no path through this block leaves a value held (no latch inferred).
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      sum       = '0;
      cand      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         sum = {1'b0, ptr} + (IDX_W+1)'(k);
         if (sum >= (IDX_W+1)'(NUM_REQ)) begin
            sum = sum - (IDX_W+1)'(NUM_REQ);
         end
         cand = sum[IDX_W-1:0];
         if (!found && req[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            grant_idx   = cand;
         end
      end
   end

endmodule

// File: rtl/mult_cell_sequencer.sv
// Shares one three-partial-product multiplier cell between NUM_REQ
// requesters. One operation is in flight at a time:
// IDLE -> ISSUE -> [WAIT] -> COMBINE -> RESP -> IDLE.
module mult_cell_sequencer
   import mult_cell_sequencer_pkg::*;
#(
   parameter int NUM_REQ      = 2,
   parameter int CELL_LATENCY = 1
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [WORD_W*NUM_REQ-1:0] req_src1,
   input  logic [WORD_W*NUM_REQ-1:0] req_src2,
   output logic [NUM_REQ-1:0]        rsp_valid,
   input  logic [NUM_REQ-1:0]        rsp_ready,
   output logic [WORD_W-1:0]         rsp_data,
   output logic                      busy,
   output logic [WORD_W-1:0]         cell_src1,
   output logic [WORD_W-1:0]         cell_src2,
   output logic                      cell_en,
   input  logic [WORD_W-1:0]         cell_p1,
   input  logic [WORD_W-1:0]         cell_p2,
   input  logic [WORD_W-1:0]         cell_p3
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = 2;

   state_t             state;
   logic [IDX_W-1:0]   rr_ptr;
   logic [IDX_W-1:0]   grant_q;
   logic [WORD_W-1:0]  op_a;
   logic [WORD_W-1:0]  op_b;
   logic [CNT_W-1:0]   lat_cnt;

   logic [NUM_REQ-1:0] arb_grant;
   logic [IDX_W-1:0]   arb_idx;
   logic               arb_found;
   logic [WORD_W-1:0]  sel_src1;
   logic [WORD_W-1:0]  sel_src2;

   mult_cell_sequencer_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_arb (
      .req       (req_valid),
      .ptr       (rr_ptr),
      .grant     (arb_grant),
      .grant_idx (arb_idx),
      .found     (arb_found)
   );

   // Operand slices of the current arbitration winner.
   always_comb begin
      sel_src1 = req_src1[int'(arb_idx)*WORD_W +: WORD_W];
      sel_src2 = req_src2[int'(arb_idx)*WORD_W +: WORD_W];
   end

   // Sequencer FSM with operand latch, latency counter and combine adder.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         rr_ptr   <= '0;
         grant_q  <= '0;
         // NOTE: the operand latches are reset as well, so cell_src reads 0
         // until the first accept instead of leaking power-up contents.
         op_a     <= '0;
         op_b     <= '0;
         lat_cnt  <= '0;
         rsp_data <= '0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every branch reads
         // the pre-edge register values regardless of statement order.
         case (state)
            ST_IDLE: begin
               if (arb_found) begin
                  op_a    <= sel_src1;
                  op_b    <= sel_src2;
                  grant_q <= arb_idx;
                  rr_ptr  <= (arb_idx == IDX_W'(NUM_REQ-1)) ? '0 : arb_idx + 1'b1;
                  state   <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (CELL_LATENCY <= 1) begin
                  state <= ST_COMBINE;
               end else begin
                  lat_cnt <= CNT_W'(CELL_LATENCY-2);
                  state   <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (lat_cnt == '0) begin
                  state <= ST_COMBINE;
               end else begin
                  lat_cnt <= lat_cnt - 1'b1;
               end
            end
            ST_COMBINE: begin
               rsp_data <= combine_partials(cell_p1, cell_p2, cell_p3);
               state    <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready[grant_q]) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Response valid is a decode of the held grant while in RESP.
   always_comb begin
      rsp_valid = '0;
      if (state == ST_RESP) begin
         rsp_valid[grant_q] = 1'b1;
      end
   end

   // Accept only in IDLE; gated by reset_n so it stays low while reset is held
   // even if a requester is already raising req_valid.
   assign req_ready = (state == ST_IDLE && reset_n) ? arb_grant : '0;
   assign busy      = (state != ST_IDLE);
   assign cell_en   = (state == ST_ISSUE);
   assign cell_src1 = op_a;
   assign cell_src2 = op_b;

endmodule

// File: tb/tb_mult_cell_sequencer.sv
// Directed self-checking bench for mult_cell_sequencer. One instance runs
// the default latency, a second runs CELL_LATENCY=3 for the WAIT and
// mid-operation reset cases. Each instance drives a behavioural cell model.
module tb_mult_cell_sequencer;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   // Default-latency instance
   logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
   logic [63:0] req_src1, req_src2;
   logic [31:0] rsp_data, cell_src1, cell_src2, cell_p1, cell_p2, cell_p3;
   logic        busy, cell_en;

   // CELL_LATENCY=3 instance
   logic [1:0]  req_valid_l3, req_ready_l3, rsp_valid_l3, rsp_ready_l3;
   logic [63:0] req_src1_l3, req_src2_l3;
   logic [31:0] rsp_data_l3, cell_src1_l3, cell_src2_l3;
   logic [31:0] cell_p1_l3, cell_p2_l3, cell_p3_l3;
   logic        busy_l3, cell_en_l3;
   logic [31:0] pipe1_l3 [3];
   logic [31:0] pipe2_l3 [3];
   logic [31:0] pipe3_l3 [3];

   logic [1:0]  seen;
   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mult_cell_sequencer #(.NUM_REQ(2), .CELL_LATENCY(1)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_src1(req_src1), .req_src2(req_src2),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .busy(busy),
      .cell_src1(cell_src1), .cell_src2(cell_src2), .cell_en(cell_en),
      .cell_p1(cell_p1), .cell_p2(cell_p2), .cell_p3(cell_p3)
   );

   mult_cell_sequencer #(.NUM_REQ(2), .CELL_LATENCY(3)) dut_l3 (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid_l3), .req_ready(req_ready_l3),
      .req_src1(req_src1_l3), .req_src2(req_src2_l3),
      .rsp_valid(rsp_valid_l3), .rsp_ready(rsp_ready_l3), .rsp_data(rsp_data_l3),
      .busy(busy_l3),
      .cell_src1(cell_src1_l3), .cell_src2(cell_src2_l3), .cell_en(cell_en_l3),
      .cell_p1(cell_p1_l3), .cell_p2(cell_p2_l3), .cell_p3(cell_p3_l3)
   );

   // Single-stage cell: partials valid the cycle after the cell_en edge.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cell_p1 <= '0;
         cell_p2 <= '0;
         cell_p3 <= '0;
      end else if (cell_en) begin
         cell_p1 <= 32'(cell_src1[15:0])  * 32'(cell_src2[15:0]);
         cell_p2 <= 32'(cell_src1[15:0])  * 32'(cell_src2[31:16]);
         cell_p3 <= 32'(cell_src1[31:16]) * 32'(cell_src2[15:0]);
      end
   end

   // Three-stage cell: partials appear two edges after the capture edge.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 3; i++) begin
            pipe1_l3[i] <= '0;
            pipe2_l3[i] <= '0;
            pipe3_l3[i] <= '0;
         end
      end else begin
         if (cell_en_l3) begin
            pipe1_l3[0] <= 32'(cell_src1_l3[15:0])  * 32'(cell_src2_l3[15:0]);
            pipe2_l3[0] <= 32'(cell_src1_l3[15:0])  * 32'(cell_src2_l3[31:16]);
            pipe3_l3[0] <= 32'(cell_src1_l3[31:16]) * 32'(cell_src2_l3[15:0]);
         end
         for (int i = 1; i < 3; i++) begin
            pipe1_l3[i] <= pipe1_l3[i-1];
            pipe2_l3[i] <= pipe2_l3[i-1];
            pipe3_l3[i] <= pipe3_l3[i-1];
         end
      end
   end

   assign cell_p1_l3 = pipe1_l3[2];
   assign cell_p2_l3 = pipe2_l3[2];
   assign cell_p3_l3 = pipe3_l3[2];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One operation on the default instance: wait (bounded) for the accept,
   // then walk ISSUE, COMBINE and into RESP, checking each stage.
   task automatic run_op(input string tag, input logic [1:0] exp_grant,
                         input logic [31:0] exp_data, input bit drop);
      int n = 0;
      #1;
      while (req_ready === 2'b00 && n < 20) begin
         tick();
         n++;
      end
      check({tag, "_ready"}, 32'(req_ready), 32'(exp_grant));
      tick();
      if (drop) req_valid = req_valid & ~exp_grant;
      check({tag, "_issue_en"}, {30'b0, busy, cell_en}, 32'b11);
      tick();
      check({tag, "_combine"}, {29'b0, cell_en, rsp_valid}, 32'd0);
      tick();
      check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(exp_grant));
      check({tag, "_rsp_data"}, rsp_data, exp_data);
   endtask

   initial begin
      req_valid    = '0;
      rsp_ready    = '0;
      req_src1     = '0;
      req_src2     = '0;
      req_valid_l3 = '0;
      rsp_ready_l3 = '0;
      req_src1_l3  = '0;
      req_src2_l3  = '0;
      seen         = '0;

      // Reset state
      #2;
      check("rst_ctl", {26'b0, req_ready, rsp_valid, busy, cell_en}, 32'd0);
      check("rst_rsp_data", rsp_data, 32'd0);
      check("rst_cell_src", cell_src1 | cell_src2, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;

      // 3 * 5 from requester 0
      req_src1[31:0] = 32'd3;
      req_src2[31:0] = 32'd5;
      rsp_ready      = 2'b11;
      req_valid      = 2'b01;
      run_op("t1", 2'b01, 32'd15, 1'b1);
      check("t1_src_hold", cell_src1, 32'd3);
      tick();
      check("t1_idle", {31'b0, busy}, 32'd0);

      // Partials exercise all three terms, requester 1 only
      req_src1[63:32] = 32'h0001_2345;
      req_src2[63:32] = 32'h0001_0002;
      req_valid       = 2'b10;
      run_op("t2", 2'b10, 32'h2347_468A, 1'b1);
      tick();

      // All-ones operands: upper half of p2+p3 and the final carry discarded
      req_src1[63:32] = 32'hFFFF_FFFF;
      req_src2[63:32] = 32'hFFFF_FFFF;
      req_valid       = 2'b10;
      run_op("t3", 2'b10, 32'h0000_0001, 1'b1);
      tick();

      // Both requesters held high: strict alternation 0,1,0,1
      req_src1  = {32'd100, 32'd7};
      req_src2  = {32'd200, 32'd9};
      req_valid = 2'b11;
      run_op("t4a", 2'b01, 32'd63, 1'b0);
      tick();
      run_op("t4b", 2'b10, 32'd20000, 1'b0);
      tick();
      run_op("t4c", 2'b01, 32'd63, 1'b0);
      tick();
      run_op("t4d", 2'b10, 32'd20000, 1'b0);
      tick();
      req_valid = 2'b00;

      // Backpressure on requester 0; requester 1 waiting, its rsp_ready ignored
      req_src1  = {32'd6, 32'd11};
      req_src2  = {32'd7, 32'd13};
      rsp_ready = 2'b10;
      req_valid = 2'b11;
      run_op("t5", 2'b01, 32'd143, 1'b1);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t5_hold_ctl", {27'b0, rsp_valid, req_ready, busy}, {27'b0, 2'b01, 2'b00, 1'b1});
         check("t5_hold_data", rsp_data, 32'd143);
      end
      rsp_ready = 2'b01;
      tick();
      check("t5_next_ready", {29'b0, req_ready, busy}, {29'b0, 2'b10, 1'b0});
      tick();
      check("t5_next_issue", {30'b0, busy, cell_en}, 32'b11);
      req_valid = 2'b00;
      rsp_ready = 2'b11;
      tick();
      tick();
      check("t5_r1_valid", 32'(rsp_valid), 32'b10);
      check("t5_r1_data", rsp_data, 32'd42);
      tick();

      // CELL_LATENCY=3: response after WAIT, at T+5
      req_src1_l3[31:0] = 32'd2;
      req_src2_l3[31:0] = 32'd3;
      rsp_ready_l3      = 2'b11;
      req_valid_l3      = 2'b01;
      #1;
      check("l3_ready0", 32'(req_ready_l3), 32'b01);
      tick();
      req_valid_l3 = 2'b00;
      tick();
      tick();
      tick();
      check("l3_no_early_rsp", 32'(rsp_valid_l3), 32'd0);
      tick();
      check("l3_rsp_valid", 32'(rsp_valid_l3), 32'b01);
      check("l3_rsp_data", rsp_data_l3, 32'd6);
      tick();

      // Reset while in WAIT with both requesters asserting
      req_src1_l3  = {32'h0001_1234, 32'd5};
      req_src2_l3  = {32'h0002_5678, 32'd7};
      req_valid_l3 = 2'b11;
      #1;
      check("l3_ready1", 32'(req_ready_l3), 32'b10);
      tick();
      check("l3_issue_src", cell_src1_l3, 32'h0001_1234);
      tick();
      check("l3_wait", {30'b0, busy_l3, cell_en_l3}, 32'b10);
      reset_n = 1'b0;
      #1;
      check("l3_rst_ctl", {26'b0, req_ready_l3, rsp_valid_l3, busy_l3, cell_en_l3}, 32'd0);
      check("l3_rst_data", rsp_data_l3, 32'd0);
      check("l3_rst_src", cell_src1_l3 | cell_src2_l3, 32'd0);
      req_valid_l3 = 2'b00;
      tick();
      tick();
      reset_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         seen = seen | rsp_valid_l3;
      end
      check("l3_no_rsp_after_rst", 32'(seen), 32'd0);
      req_valid_l3 = 2'b11;
      #1;
      check("l3_first_grant", 32'(req_ready_l3), 32'b01);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
